// File: rtl/diff_core_pkg.sv
// diff_core_pkg: shared constants and bank-state type for the ping-pong buffer bank
package diff_core_pkg;
    localparam int CONF_PP_NUM_CH = 8;
    localparam int CONF_PP_DEPTH  = 1024;
    typedef struct packed {
        logic [1:0] full;
        logic       wr_sel;
        logic       rd_sel;
    } pp_bank_state_t;
endpackage

// File: rtl/two_port_mem.sv
// two_port_mem: one write port, one registered read port; ports: clk, clr_i (clears read reg), we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o
module two_port_mem #(
    parameter int W  = 8,
    parameter int D  = 2048,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [D];
    logic [W-1:0] rdata_q;
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    always_ff @(posedge clk)
        if (clr_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    assign rdata_o = rdata_q;
endmodule

// File: rtl/diff_pp_buf_bank.sv
// diff_pp_buf_bank: multi-channel ping-pong buffer bank with commit/release handshake; ports: write side (wr_*), read side (rd_*), sticky error flags, flush
module diff_pp_buf_bank
    import diff_core_pkg::*;
#(
    parameter int NUM_CH     = CONF_PP_NUM_CH,
    parameter int BIT_LENGTH = 8,
    parameter int DEPTH      = CONF_PP_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            wr_ch_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [BIT_LENGTH-1:0]        wr_data,
    output logic                         wr_ready,
    input  logic                         wr_commit,
    output logic                         rd_valid,
    output logic [ADDR_W:0]              rd_len,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [NUM_CH*BIT_LENGTH-1:0] rd_data,
    output logic                         rd_data_valid,
    input  logic                         rd_release,
    output logic                         err_overrun,
    output logic                         err_underrun
);
    pp_bank_state_t        st_q, st_d;
    logic [1:0][ADDR_W:0]  len_q, len_d;
    logic                  err_overrun_q, err_overrun_d;
    logic                  err_underrun_q, err_underrun_d;
    logic                  rd_data_valid_q;
    logic                  clr, wr_any, do_commit, do_rel;
    logic [ADDR_W:0]       wr_len;

    assign clr       = rst | flush;
    assign wr_ready  = ~st_q.full[st_q.wr_sel];
    assign rd_valid  = st_q.full[st_q.rd_sel];
    assign rd_len    = st_q.rd_sel ? len_q[1] : len_q[0];
    assign wr_any    = |wr_ch_en;
    assign do_commit = wr_commit & wr_ready;
    assign do_rel    = rd_release & rd_valid;
    assign wr_len    = {1'b0, wr_addr} + 1'b1;

    // A legal commit needs its bank empty and a legal release needs its bank full,
    // so the two can never target the same bank in one cycle.
    always_comb begin
        st_d           = st_q;
        len_d          = len_q;
        err_overrun_d  = err_overrun_q | ((wr_any | wr_commit) & ~wr_ready);
        err_underrun_d = err_underrun_q | (rd_release & ~rd_valid);
        if (wr_any & wr_ready & (wr_len > len_q[st_q.wr_sel])) len_d[st_q.wr_sel] = wr_len;
        if (do_commit) begin
            st_d.full[st_q.wr_sel] = 1'b1;
            st_d.wr_sel            = ~st_q.wr_sel;
        end
        if (do_rel) begin
            st_d.full[st_q.rd_sel] = 1'b0;
            st_d.rd_sel            = ~st_q.rd_sel;
            len_d[st_q.rd_sel]     = '0;
        end
    end

    always_ff @(posedge clk)
        if (clr) begin
            st_q            <= '0;
            len_q           <= '0;
            err_overrun_q   <= 1'b0;
            err_underrun_q  <= 1'b0;
            rd_data_valid_q <= 1'b0;
        end else begin
            st_q            <= st_d;
            len_q           <= len_d;
            err_overrun_q   <= err_overrun_d;
            err_underrun_q  <= err_underrun_d;
            rd_data_valid_q <= rd_en & rd_valid;
        end

    assign err_overrun   = err_overrun_q;
    assign err_underrun  = err_underrun_q;
    assign rd_data_valid = rd_data_valid_q;

    // Bank select forms the address MSB; the read register is cleared with the bank state.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        two_port_mem #(.W(BIT_LENGTH), .D(2 * DEPTH)) u_mem (
            .clk     (clk),
            .clr_i   (clr),
            .we_i    (wr_ch_en[c] & wr_ready),
            .waddr_i ({st_q.wr_sel, wr_addr}),
            .wdata_i (wr_data),
            .re_i    (rd_en & ~clr),
            .raddr_i ({st_q.rd_sel, rd_addr}),
            .rdata_o (rd_data[c*BIT_LENGTH +: BIT_LENGTH])
        );
    end
endmodule
